// File: rtl/irq_ctrl16_if.sv
// Request/mask/handshake bundle between an interrupt consumer and irq_ctrl16.
interface irq_ctrl16_if;
  logic        en;
  logic [15:0] req;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        ack;
  logic        eoi;
  logic        irq;
  logic [3:0]  vec;
  logic        busy;
  logic        eo;
  logic [15:0] mask;
  logic [15:0] pending;

  modport master (
    output en, req, mask_we, mask_wdata, ack, eoi,
    input  irq, vec, busy, eo, mask, pending
  );

  modport slave (
    input  en, req, mask_we, mask_wdata, ack, eoi,
    output irq, vec, busy, eo, mask, pending
  );
endinterface

// File: rtl/irq_ctrl16.sv
// Sixteen-line prioritized interrupt controller with irq/ack/eoi delivery.
// Define IRQ_EDGE_EN for edge-triggered capture; default build is level-sensitive.
module irq_ctrl16 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  irq_ctrl16_if.slave   bus
);
  localparam int unsigned N  = 16;
  localparam int unsigned VW = 4;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [N-1:0]    sync_q [SYNC_STAGES];
  logic [N-1:0]    s;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    cand;
  logic [VW-1:0]   win;
  logic [VW-1:0]   vec_q;
  logic            irq_q;
  logic            busy_q;

  // Per-bit synchronizer chain for the asynchronous request lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.req;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_EN
  logic [N-1:0] s_d;
  logic [N-1:0] clr_c;

  // Ack clears the served bit; a coincident new edge on that bit still sets it
  assign clr_c = (state == REQ && bus.ack) ? (N'(1) << vec_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d       <= '0;
      pending_q <= '0;
    end else begin
      s_d       <= s;
      pending_q <= (pending_q & ~clr_c) | (s & ~s_d);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mask_q <= '1;
    else if (bus.mask_we) mask_q <= bus.mask_wdata;
  end

  assign cand = pending_q & ~mask_q;

  // Highest set index wins
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) win = VW'(i);
    end
  end

  // Delivery FSM; vec is latched only on IDLE->REQ so it stays stable in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vec_q  <= '0;
      irq_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && cand != '0) begin
            state <= REQ;
            vec_q <= win;
            irq_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ack) begin
            state  <= SERVICE;
            irq_q  <= 1'b0;
            busy_q <= 1'b1;
          end else if (!bus.en) begin
            state <= IDLE;
            irq_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          irq_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.vec     = vec_q;
  assign bus.busy    = busy_q;
  assign bus.mask    = mask_q;
  assign bus.pending = pending_q;
  assign bus.eo      = bus.en & (cand == '0);

endmodule
